// File: rtl/thread_fetch_scheduler.sv
// Per-thread PC file with a rotating-priority thread picker that feeds the fetch stage.
// Optional macro THREAD_SCHED_STATS_EN adds a saturating idle-cycle counter output.
module thread_fetch_scheduler #(
  parameter int                    NUM_THREADS   = 4,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDR_WIDTH-1:0] THREAD_STRIDE = ADDR_WIDTH'(32'h0000_1000),
  localparam int                   TID_W         = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_redirect_valid,
  input  logic [TID_W-1:0]       i_redirect_thread,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
  input  logic                   i_block_valid,
  input  logic [TID_W-1:0]       i_block_thread,
  input  logic                   i_wake_valid,
  input  logic [TID_W-1:0]       i_wake_thread,
  output logic                   o_fetch_valid,
  output logic [ADDR_WIDTH-1:0]  o_fetch_pc,
  output logic [TID_W-1:0]       o_fetch_thread,
  output logic [NUM_THREADS-1:0] o_ready_mask
`ifdef THREAD_SCHED_STATS_EN
  ,
  output logic [31:0]            o_idle_cycles
`endif
);

  // Handshake: o_fetch_valid/pc/thread form a registered request; fetch applies
  // backpressure with i_stall, which freezes the request, all PCs and the rotation.

  logic [ADDR_WIDTH-1:0]  pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] ready_q;
  logic [NUM_THREADS-1:0] ready_nxt;
  logic [NUM_THREADS-1:0] eligible;
  logic [TID_W-1:0]       last_tid;
  logic [TID_W-1:0]       cand;
  logic [TID_W-1:0]       win_tid;
  logic                   win_found;
  logic                   eff_block;

  // A wake naming the same thread cancels the block, so the thread stays eligible.
  assign eff_block = i_block_valid && !(i_wake_valid && (i_wake_thread == i_block_thread));

  always_comb begin
    eligible = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t] = ready_q[t]
                    && !(eff_block && (i_block_thread == TID_W'(t)))
                    && !(i_redirect_valid && (i_redirect_thread == TID_W'(t)));
    end
  end

  // Rotating priority starting just after the last winner; TID_W wrap gives the modulo.
  always_comb begin
    win_found = 1'b0;
    win_tid   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      cand = last_tid + TID_W'(k + 1);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_tid   = cand;
      end
    end
  end

  always_comb begin
    ready_nxt = ready_q;
    if (i_block_valid) ready_nxt[i_block_thread] = 1'b0;
    if (i_wake_valid)  ready_nxt[i_wake_thread]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC + ADDR_WIDTH'(t) * THREAD_STRIDE;
      end
      ready_q        <= '1;
      last_tid       <= TID_W'(NUM_THREADS - 1);
      o_fetch_valid  <= 1'b0;
      o_fetch_pc     <= '0;
      o_fetch_thread <= '0;
    end else begin
      if (!i_stall) begin
        if (win_found) begin
          o_fetch_valid   <= 1'b1;
          o_fetch_pc      <= pc_q[win_tid];
          o_fetch_thread  <= win_tid;
          last_tid        <= win_tid;
          pc_q[win_tid]   <= pc_q[win_tid] + ADDR_WIDTH'(4);
        end else begin
          o_fetch_valid <= 1'b0;
        end
      end
      // A redirected thread is never the winner, but the later write also wins by order.
      if (i_redirect_valid) pc_q[i_redirect_thread] <= i_redirect_target;
      ready_q <= ready_nxt;
    end
  end

  assign o_ready_mask = ready_q;

`ifdef THREAD_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_idle_cycles <= '0;
    end else if (!i_stall && !win_found && (o_idle_cycles != 32'hFFFF_FFFF)) begin
      o_idle_cycles <= o_idle_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Bench for thread_fetch_scheduler: directed vector table, async reset check, then
// randomized traffic against an array-based reference model.
module tb_thread_fetch_scheduler;

  localparam int NT = 4;
  localparam int AW = 32;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_stall = 1'b0;
  logic          i_redirect_valid = 1'b0;
  logic [TW-1:0] i_redirect_thread = '0;
  logic [AW-1:0] i_redirect_target = '0;
  logic          i_block_valid = 1'b0;
  logic [TW-1:0] i_block_thread = '0;
  logic          i_wake_valid = 1'b0;
  logic [TW-1:0] i_wake_thread = '0;
  logic          o_fetch_valid;
  logic [AW-1:0] o_fetch_pc;
  logic [TW-1:0] o_fetch_thread;
  logic [NT-1:0] o_ready_mask;
`ifdef THREAD_SCHED_STATS_EN
  logic [31:0]   o_idle_cycles;
`endif

  thread_fetch_scheduler #(
    .NUM_THREADS(NT), .ADDR_WIDTH(AW), .RESET_PC(32'h0), .THREAD_STRIDE(32'h0000_1000)
  ) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall),
    .i_redirect_valid(i_redirect_valid), .i_redirect_thread(i_redirect_thread),
    .i_redirect_target(i_redirect_target),
    .i_block_valid(i_block_valid), .i_block_thread(i_block_thread),
    .i_wake_valid(i_wake_valid), .i_wake_thread(i_wake_thread),
    .o_fetch_valid(o_fetch_valid), .o_fetch_pc(o_fetch_pc),
    .o_fetch_thread(o_fetch_thread), .o_ready_mask(o_ready_mask)
`ifdef THREAD_SCHED_STATS_EN
    , .o_idle_cycles(o_idle_cycles)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          rv;
    logic [TW-1:0] rt;
    logic [AW-1:0] rtgt;
    logic          bv;
    logic [TW-1:0] bt;
    logic          wv;
    logic [TW-1:0] wt;
    logic          ev;
    logic [AW-1:0] epc;
    logic [TW-1:0] eth;
    logic [NT-1:0] emask;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // reference model state
  logic [AW-1:0] m_pc [NT];
  logic          m_ready [NT];
  int            m_last;
  logic          m_valid;
  logic [AW-1:0] m_fpc;
  int            m_fth;
  int            m_idle;

  function automatic vec_t mk(input logic s, input logic rv, input int rt, input logic [AW-1:0] rtgt,
                              input logic bv, input int bt, input logic wv, input int wt,
                              input logic ev, input logic [AW-1:0] epc, input int eth,
                              input logic [NT-1:0] emask);
    vec_t v;
    v.stall = s; v.rv = rv; v.rt = TW'(rt); v.rtgt = rtgt;
    v.bv = bv; v.bt = TW'(bt); v.wv = wv; v.wt = TW'(wt);
    v.ev = ev; v.epc = epc; v.eth = TW'(eth); v.emask = emask;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs set now (at a negedge), outputs sampled 1 unit after the next posedge
  task automatic apply(input vec_t v);
    i_stall = v.stall;
    i_redirect_valid = v.rv; i_redirect_thread = v.rt; i_redirect_target = v.rtgt;
    i_block_valid = v.bv; i_block_thread = v.bt;
    i_wake_valid = v.wv; i_wake_thread = v.wt;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_pc[t] = 32'h0000_1000 * t;
      m_ready[t] = 1'b1;
    end
    m_last = NT - 1;
    m_valid = 1'b0; m_fpc = '0; m_fth = 0; m_idle = 0;
  endtask

  task automatic model_step(input vec_t v);
    bit elig [NT];
    int win = -1;
    for (int t = 0; t < NT; t++) begin
      elig[t] = m_ready[t]
                && !(v.bv && int'(v.bt) == t && !(v.wv && int'(v.wt) == t))
                && !(v.rv && int'(v.rt) == t);
    end
    if (!v.stall) begin
      for (int k = 1; k <= NT; k++) begin
        if (win < 0 && elig[(m_last + k) % NT]) win = (m_last + k) % NT;
      end
      if (win >= 0) begin
        m_valid = 1'b1; m_fpc = m_pc[win]; m_fth = win;
        m_pc[win] = m_pc[win] + 32'd4;
        m_last = win;
      end else begin
        m_valid = 1'b0;
        m_idle++;
      end
    end
    if (v.rv) m_pc[v.rt] = v.rtgt;
    if (v.bv) m_ready[v.bt] = 1'b0;
    if (v.wv) m_ready[v.wt] = 1'b1;
  endtask

  function automatic logic [NT-1:0] model_mask();
    logic [NT-1:0] m;
    for (int t = 0; t < NT; t++) m[t] = m_ready[t];
    return m;
  endfunction

  initial begin
    // directed vectors: stall, redirect, block, wake, block+wake, redirect while blocked, wrap
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_0000,0,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_1000,1,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_2000,2,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_3000,3,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_0004,0,4'hF));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h0000_0004,0,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_1004,1,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_2004,2,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_3004,3,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_0008,0,4'hF));
    vecs.push_back(mk(0,1,1,32'h0000_8000, 0,0,0,0, 1,32'h0000_2008,2,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_3008,3,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_000C,0,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_8000,1,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_200C,2,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_300C,3,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_0010,0,4'hF));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_8004,1,4'hF));
    vecs.push_back(mk(0,0,0,0, 1,2,0,0, 1,32'h0000_3010,3,4'hB));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h0000_8008,1,4'hA));
    vecs.push_back(mk(0,0,0,0, 1,1,0,0, 1,32'h0000_3014,3,4'h8));
    vecs.push_back(mk(0,0,0,0, 1,3,0,0, 0,32'h0000_3014,3,4'h0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,32'h0000_3014,3,4'h0));
    vecs.push_back(mk(0,0,0,0, 0,0,1,2, 0,32'h0000_3014,3,4'h4));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_2010,2,4'h4));
    vecs.push_back(mk(0,0,0,0, 0,0,1,3, 1,32'h0000_2014,2,4'hC));
    vecs.push_back(mk(0,0,0,0, 1,3,1,3, 1,32'h0000_3018,3,4'hC));
    vecs.push_back(mk(0,0,0,0, 1,2,0,0, 1,32'h0000_301C,3,4'h8));
    vecs.push_back(mk(0,1,1,32'h0000_5000, 0,0,0,0, 1,32'h0000_3020,3,4'h8));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1, 1,32'h0000_3024,3,4'hA));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_5000,1,4'hA));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_3028,3,4'hA));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_5004,1,4'hA));
    vecs.push_back(mk(0,1,1,32'hFFFF_FFFC, 0,0,0,0, 1,32'h0000_302C,3,4'hA));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hFFFF_FFFC,1,4'hA));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_3030,3,4'hA));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h0000_0000,1,4'hA));

    // reset state
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(o_fetch_valid), 32'd0);
    check("reset_pc", o_fetch_pc, 32'd0);
    check("reset_thread", 32'(o_fetch_thread), 32'd0);
    check("reset_mask", 32'(o_ready_mask), 32'hF);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check($sformatf("vec%0d_valid", i), 32'(o_fetch_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_pc", i), o_fetch_pc, vecs[i].epc);
      check($sformatf("vec%0d_thread", i), 32'(o_fetch_thread), 32'(vecs[i].eth));
      check($sformatf("vec%0d_mask", i), 32'(o_ready_mask), 32'(vecs[i].emask));
      @(negedge clk);
    end
`ifdef THREAD_SCHED_STATS_EN
    check("idle_cycles_directed", o_idle_cycles, 32'd3);
`endif

    // async reset asserted between edges clears outputs without a clock edge
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(o_fetch_valid), 32'd0);
    check("async_rst_pc", o_fetch_pc, 32'd0);
    check("async_rst_thread", 32'(o_fetch_thread), 32'd0);
    check("async_rst_mask", 32'(o_ready_mask), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      v = mk(0,0,0,0, 0,0,0,0, 0,0,0,0);
      v.stall = ($urandom_range(0, 4) == 0);
      v.rv    = ($urandom_range(0, 5) == 0);
      v.rt    = TW'($urandom_range(0, NT - 1));
      v.rtgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 + 32'd4 * $urandom_range(0, 2))
                                           : ($urandom() & 32'hFFFF_FFFC);
      v.bv    = ($urandom_range(0, 3) == 0);
      v.bt    = TW'($urandom_range(0, NT - 1));
      v.wv    = ($urandom_range(0, 2) == 0);
      v.wt    = TW'($urandom_range(0, NT - 1));
      model_step(v);
      apply(v);
      check("rand_valid", 32'(o_fetch_valid), 32'(m_valid));
      check("rand_pc", o_fetch_pc, m_fpc);
      check("rand_thread", 32'(o_fetch_thread), 32'(m_fth));
      check("rand_mask", 32'(o_ready_mask), 32'(model_mask()));
`ifdef THREAD_SCHED_STATS_EN
      check("rand_idle", o_idle_cycles, 32'(m_idle));
`endif
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_fetch_scheduler.md
# thread_fetch_scheduler

Per-thread PC file and round-robin thread selector sitting directly upstream of the fetch stage in the multithreaded MIPS core. Each cycle it picks one ready hardware thread. It presents that thread's PC and `thread_id` to fetch, then advances the PC. It also applies per-thread redirects from decode branch resolution and block/wake events from the memory stage.

## Interface
Parameters:
- `NUM_THREADS`, 4: hardware threads; power of two, ≥2; `TID_W = $clog2(NUM_THREADS)`
- `ADDR_WIDTH`, 32: PC width
- `RESET_PC`, 0: reset PC of thread 0
- `THREAD_STRIDE`, 32'h0000_1000: thread t resets to `RESET_PC + t*THREAD_STRIDE`

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `i_stall` in 1: fetch stalled by hazard controller
- `i_redirect_valid` in 1: resolved branch/jump redirect
- `i_redirect_thread` in TID_W: thread being redirected
- `i_redirect_target` in ADDR_WIDTH: new PC
- `i_block_valid` in 1: thread must sleep (cache miss)
- `i_block_thread` in TID_W: thread to block
- `i_wake_valid` in 1: miss serviced
- `i_wake_thread` in TID_W: thread to wake
- `o_fetch_valid` out 1: fetch request valid
- `o_fetch_pc` out ADDR_WIDTH: PC to fetch
- `o_fetch_thread` out TID_W: thread of the fetch
- `o_ready_mask` out NUM_THREADS: bit t = thread t READY (registered state)

## Operation
- Per-thread state: `pc[t]` and a status of READY or BLOCKED.
- Eligible(t) = READY and not blocked this cycle and not redirected this cycle.
- Selection uses rotating priority, starting at `last_tid+1` mod NUM_THREADS. The first eligible thread wins.
- If a thread wins and `i_stall`=0:
  - Outputs load `{1, pc[win], win}`.
  - `pc[win] += 4`, modulo 2^ADDR_WIDTH.
  - `last_tid = win`.
- If no thread is eligible and `i_stall`=0: `o_fetch_valid` loads 0, while `o_fetch_pc`, `o_fetch_thread` and `last_tid` hold.
- If `i_stall`=1: all outputs, all PCs and `last_tid` hold. Redirect, block and wake are still applied.
- Redirect: `pc[i_redirect_thread] = i_redirect_target`, used as-is. This overrides any increment. It does not change READY/BLOCKED status.
- Block sets BLOCKED. Wake sets READY. If block and wake name the same thread in the same cycle, wake wins and the thread ends READY. Wake of a READY thread is a no-op.
- Flushing in-flight instructions of a redirected thread is the hazard controller's job, not this block's.

## Timing
- Reset, asynchronous:
  - `pc[t] = RESET_PC + t*THREAD_STRIDE`
  - all threads READY, `last_tid = NUM_THREADS-1`
  - `o_fetch_valid = 0`, `o_fetch_pc = 0`, `o_fetch_thread = 0`, `o_ready_mask` all ones
- First request: thread 0 at `RESET_PC`, valid after the first clock edge with `rst` low and `i_stall` low.
- Latency: selection happens in cycle N; outputs update at the end of N.
- Redirect sampled in cycle N: the thread is excluded in N and eligible in N+1. The target PC appears on `o_fetch_pc` at the end of N+1 at the earliest.
- Block sampled in N excludes the thread immediately in N. Wake sampled in N makes the thread eligible in N+1.
- Reset asserted mid-operation discards all state within the same cycle.

## Configuration
- `THREAD_SCHED_STATS_EN` defined:
  - Adds output `o_idle_cycles`, 32 bits.
  - Counts cycles with `i_stall`=0 and no eligible thread.
  - Saturates at 32'hFFFF_FFFF and resets to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, no stall, defaults: outputs sequence thread/PC (0,0x0), (1,0x1000), (2,0x2000), (3,0x3000), (0,0x4), then continue round-robin.
- Stall 3 cycles mid-stream: outputs and PCs frozen. On release, the next thread in rotation issues with no skip or duplicate.
- Redirect thread 1 to 0x8000 in the cycle thread 1 would win: thread 2 issues that cycle, and thread 1's next fetch is 0x8000, then 0x8004.
- Block threads 0–3 together: `o_fetch_valid`=0 and `o_ready_mask`=0. Wake thread 2: exactly one cycle later thread 2 issues at its saved PC. With the macro defined, `o_idle_cycles` equals the idle cycle count.
- Simultaneous block and wake on thread 3: thread 3 stays READY and is selected normally. A redirect on a BLOCKED thread updates its PC, and the thread resumes at the target after wake.
- `pc` = 0xFFFF_FFFC issued with ADDR_WIDTH=32: the next fetch for that thread is 0x0. Async reset asserted between edges clears outputs immediately.
